keypad_emulator: RTL and testbench
==================================

Name: keypad_emulator

Overview:
- Behavioural stand-in for the physical 4x4 matrix keypad. Sits on the far end of the row/column interface that the keypad scanner drives.
- Accepts key requests over a valid/ready handshake and holds the requested key closed for a programmed time, then open for a programmed time.
- Answers the scanner's active-low row drive with active-low column levels.
- Used for FPGA loopback self-test and as a synthesizable bench model for the scanner.

Parameters:
- HOLD_CYCLES, 1000: clk cycles the contact stays in the pressed phase; legal range is 1 or more.
- RELEASE_CYCLES, 1000: clk cycles of the mandatory open phase after a press; legal range is 1 or more.
- BOUNCE_CYCLES, 8: length of the bounce window at each contact edge. Used only with KEYPAD_BOUNCE_EN. Must be less than HOLD_CYCLES and less than RELEASE_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- key_valid  in  1  request to press a key
- key_code  in  4  position code: [3:2] = row index, [1:0] = column index
- key_ready  out  1  emulator idle; a request is accepted this cycle if key_valid is also high
- rows  in  4  scanner row drive, active-low (rows[r]==0 means row r is driven)
- cols  out  4  column sense, active-low, idle 4'b1111
- busy  out  1  high in PRESS or RELEASE
- done  out  1  one-cycle pulse at the end of RELEASE

Behaviour:
- All state is clocked on the rising edge of clk. Reset is synchronous and active-low.
- While reset==0, on the next edge:
  - state becomes IDLE
  - cols = 4'b1111, key_ready = 1, busy = 0, done = 0
  - counters and the latched code are cleared
  - contact is open
- Reset asserted mid-PRESS or mid-RELEASE aborts the press immediately, with no done pulse.
- States:
  - IDLE: key_ready = 1, contact open. When key_valid && key_ready, latch key_code, clear the counter, go to PRESS.
  - PRESS: key_ready = 0, busy = 1, contact closed. The counter increments each cycle. When counter == HOLD_CYCLES-1, clear the counter and go to RELEASE.
  - RELEASE: key_ready = 0, busy = 1, contact open. The counter increments each cycle. When counter == RELEASE_CYCLES-1, go to IDLE and assert done for exactly that transition cycle (done registered high for one cycle).
- Handshake:
  - key_valid is ignored while key_ready = 0; there is no queueing.
  - key_code is sampled only on the accept cycle. Later changes have no effect on the active press.
  - Back-to-back: a request held high during RELEASE is accepted on the first IDLE cycle, so IDLE lasts exactly 1 cycle.
- Counter width: $clog2 of the largest of HOLD_CYCLES, RELEASE_CYCLES and BOUNCE_CYCLES, plus 1. The counter never wraps within a phase.
- Column output (registered, 1-cycle latency from rows and contact):
  - cols_next[c] = 0 iff contact is closed, c == latched col, and rows[latched row] == 0. Otherwise 1.
  - A driven row other than the latched row leaves cols at 1111.
  - Several rows driven low at once: only the latched row matters.
  - rows == 4'b1111 gives cols = 1111.
  - rows changes take effect on cols one edge later, inside the scanner's two-cycle settle window.
- Press timing:
  - The first cycle cols can show 0 is the edge after entry to PRESS.
  - The last such cycle is the edge after the final PRESS cycle.
  - Pressed visibility totals exactly HOLD_CYCLES cycles, given continuous row drive.
- Only one key is emulated at a time; cols never has more than one bit low.

Optional Feature:
- Macro: KEYPAD_BOUNCE_EN.
- Defined:
  - During the first BOUNCE_CYCLES cycles of PRESS, contact = closed when counter[0]==0 and open when counter[0]==1. After that it is solid closed.
  - During the first BOUNCE_CYCLES cycles of RELEASE, contact = open when counter[0]==0 and closed when counter[0]==1. After that it is solid open.
  - Phase lengths, handshake and done timing are unchanged.
- Undefined:
  - Contact is solid closed for all of PRESS and solid open for all of RELEASE.
  - BOUNCE_CYCLES is unused and no bounce logic is synthesized.

Test Plan:
- Reset and idle (HOLD=20, RELEASE=10): hold reset=0 for 3 cycles with rows=4'b0000 -> cols=1111, key_ready=1, busy=0, done=0. Release reset and keep it idle 5 cycles -> unchanged.
- Single press:
  - Stimulus: key_code=4'b0110 (row 1, col 2) accepted at cycle T; rows held at 4'b1101.
  - cols: 4'b1011 from T+2 through T+21 (20 cycles), then 1111.
  - done: high only at T+31.
  - key_ready: low from T+1 through T+30, high again at T+31.
- Row selectivity: same press with rows cycling 1110→1101→1011→0111, 2 cycles each -> cols=1011 only on the cycle after each rows=1101 cycle, else 1111. With rows=4'b0000 -> cols=1011 for the whole hold.
- Handshake:
  - Assert key_valid with code 4'b1111 continuously from T.
  - Second accept occurs exactly at T+31.
  - A change to key_code during PRESS to 4'b0000 does not move the low column away from col 3.
  - cols=0111 when rows[3]==0.
- Reset mid-press: reset=0 at T+8 of a press -> next edge cols=1111, state IDLE, key_ready=1, and no done pulse ever occurs for that press.
- Bounce (KEYPAD_BOUNCE_EN, BOUNCE=4, rows=0000, code 4'b0000):
  - cols[0] after accept: 0,1,0,1, then 0 for 16 cycles.
  - Then 1,0,1,0, then 1 for 6 cycles.
  - Without the macro: 0 for 20 cycles, then 1.

Source files
------------

// File: rtl/keypad_emulator.sv
// keypad_emulator: behavioural stand-in for a 4x4 matrix keypad.
// Accepts one key request at a time over a valid/ready handshake. It holds the
// requested contact closed for HOLD_CYCLES, then open for RELEASE_CYCLES.
// While the contact is closed and the scanner drives the key's row low, the
// key's column is pulled low. The column response is registered, so it
// follows rows one clock later.
// Optional feature: define KEYPAD_BOUNCE_EN to make the contact alternate
// during the first BOUNCE_CYCLES of each phase.
module keypad_emulator #(
  parameter int HOLD_CYCLES    = 1000,
  parameter int RELEASE_CYCLES = 1000,
  parameter int BOUNCE_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       reset,      // synchronous, active-low
  input  logic       key_valid,
  input  logic [3:0] key_code,   // [3:2] row, [1:0] column
  output logic       key_ready,
  input  logic [3:0] rows,       // active-low row drive from the scanner
  output logic [3:0] cols,       // active-low column sense, idle 4'b1111
  output logic       busy,
  output logic       done
);

  // Counter sized for the longest phase (or bounce window) so it never wraps.
  localparam int MAX_HR  = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
  localparam int MAX_ALL = (MAX_HR > BOUNCE_CYCLES) ? MAX_HR : BOUNCE_CYCLES;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   count_q;
  logic [1:0]      row_q;
  logic [1:0]      col_q;
  logic            ready_q;
  logic            busy_q;
  logic            done_q;
  logic [3:0]      cols_q;

  logic            contact_d;
  logic            row_driven_d;
  logic [3:0]      cols_d;

  // Contact level for the current cycle; derived from phase and phase counter.
  always_comb begin
    contact_d = 1'b0;
    case (state_q)
      ST_PRESS: begin
        contact_d = 1'b1;
`ifdef KEYPAD_BOUNCE_EN
        // Bouncing make: closed on even counts, open on odd counts.
        if ((count_q < CW'(BOUNCE_CYCLES)) && count_q[0]) begin
          contact_d = 1'b0;
        end
`endif
      end
      ST_RELEASE: begin
        contact_d = 1'b0;
`ifdef KEYPAD_BOUNCE_EN
        // Bouncing break: open on even counts, closed on odd counts.
        if ((count_q < CW'(BOUNCE_CYCLES)) && count_q[0]) begin
          contact_d = 1'b1;
        end
`endif
      end
      default: contact_d = 1'b0;
    endcase
  end

  // Only the latched row matters; other driven rows are ignored.
  assign row_driven_d = ~rows[row_q];

  // Each column goes low only when it is the latched column and the key is
  // both closed and scanned. At most one column can be low at a time.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign cols_d[gi] = ~(contact_d && row_driven_d && (col_q == 2'(gi)));
    end
  endgenerate

  // Press/release sequencer with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (key_valid && ready_q) begin
            row_q   <= key_code[3:2];
            col_q   <= key_code[1:0];
            count_q <= '0;
            state_q <= ST_PRESS;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_PRESS: begin
          if (count_q == HOLD_LAST) begin
            count_q <= '0;
            state_q <= ST_RELEASE;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (count_q == RELEASE_LAST) begin
            count_q <= '0;
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        default: begin
          count_q <= '0;
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Register the column response. This gives a one-cycle lag from rows and contact.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cols_q <= 4'b1111;
    end else begin
      cols_q <= cols_d;
    end
  end

  assign key_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cols      = cols_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Testbench for keypad_emulator. A reference model tracks each press by its
// cycle offset from the accept edge and predicts cols/key_ready/busy/done.
// The stimulus is a set of directed scenarios followed by randomized traffic.
module tb_keypad_emulator;

  localparam int H = 20;
  localparam int R = 10;
  localparam int B = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  // Model: active press, offset p (1 = first PRESS cycle), latched code.
  bit         m_active = 1'b0;
  int         m_p = 0;
  logic [3:0] m_code = 4'h0;
  logic [3:0] e_cols;
  logic       e_ready, e_busy, e_done;

  keypad_emulator #(
    .HOLD_CYCLES(H),
    .RELEASE_CYCLES(R),
    .BOUNCE_CYCLES(B)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_ready(key_ready),
    .rows(rows),
    .cols(cols),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cycle, obs, exp);
    end
  endtask

  // Contact is closed in cycles 1..H of a press, and open in cycles H+1..H+R.
  function automatic bit model_contact(input bit act, input int p);
    int c;
    if (!act) return 1'b0;
    if (p >= 1 && p <= H) begin
      c = p - 1;
`ifdef KEYPAD_BOUNCE_EN
      if (c < B) return (c % 2) == 0;
`endif
      return 1'b1;
    end
    if (p > H && p <= H + R) begin
      c = p - H - 1;
`ifdef KEYPAD_BOUNCE_EN
      if (c < B) return (c % 2) == 1;
`endif
      return 1'b0;
    end
    return 1'b0;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic step(input bit v, input logic [3:0] code, input logic [3:0] r, input bit rst_n);
    logic [3:0] one;
    int         rr;
    key_valid = v;
    key_code  = code;
    rows      = r;
    reset     = rst_n;
    if (!rst_n) begin
      e_cols   = 4'b1111;
      e_ready  = 1'b1;
      e_busy   = 1'b0;
      e_done   = 1'b0;
      m_active = 1'b0;
      m_p      = 0;
    end else begin
      rr  = int'(m_code[3:2]);
      one = 4'b0001 << m_code[1:0];
      if (model_contact(m_active, m_p) && r[rr] == 1'b0) e_cols = ~one;
      else e_cols = 4'b1111;
      e_done = m_active && (m_p == H + R);
      if (m_active) begin
        m_p++;
        if (m_p > H + R) begin
          m_active = 1'b0;
          m_p      = 0;
        end
      end else if (v) begin
        m_active = 1'b1;
        m_p      = 1;
        m_code   = code;
      end
      e_ready = !m_active;
      e_busy  = m_active;
    end
    @(posedge clk);
    @(negedge clk);
    cycle++;
    check_val("cols", 32'(cols), 32'(e_cols));
    check_val("key_ready", 32'(key_ready), 32'(e_ready));
    check_val("busy", 32'(busy), 32'(e_busy));
    check_val("done", 32'(done), 32'(e_done));
  endtask

  function automatic logic [3:0] rand_rows();
    logic [3:0] one;
    case ($urandom_range(0, 3))
      0: return 4'b0000;
      1: return 4'b1111;
      2: begin
        one = 4'b0001 << $urandom_range(0, 3);
        return ~one;
      end
      default: return 4'($urandom());
    endcase
  endfunction

  initial begin
    logic [3:0] cyc_rows [4];
    cyc_rows[0] = 4'b1110;
    cyc_rows[1] = 4'b1101;
    cyc_rows[2] = 4'b1011;
    cyc_rows[3] = 4'b0111;

    // Reset with all rows driven, then stay idle.
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 4'b0000, 1'b1);

    // Single press on row 1, column 2, with only row 1 driven.
    step(1'b1, 4'b0110, 4'b1101, 1'b1);
    for (int i = 0; i < 34; i++) step(1'b0, 4'($urandom()), 4'b1101, 1'b1);

    // Row selectivity: rows rotate every two cycles.
    step(1'b1, 4'b0110, cyc_rows[0], 1'b1);
    for (int i = 1; i < 36; i++) step(1'b0, 4'h0, cyc_rows[(i / 2) % 4], 1'b1);

    // All rows driven: the column stays low for the whole hold.
    step(1'b1, 4'b0110, 4'b0000, 1'b1);
    for (int i = 0; i < 34; i++) step(1'b0, 4'h0, 4'b0000, 1'b1);

    // Back-to-back requests; key_code changes mid-press, which must not matter.
    for (int i = 0; i < 70; i++)
      step(1'b1, (i >= 5 && i < 20) ? 4'b0000 : 4'b1111, 4'b0111, 1'b1);
    for (int i = 0; i < 35; i++) step(1'b0, 4'h0, 4'b0111, 1'b1);

    // Reset mid-press aborts without a done pulse.
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 4'h0, 4'b0000, 1'b1);
    step(1'b0, 4'h0, 4'b0000, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 4'h0, 4'b0000, 1'b1);

    // Bounce-shape check on column 0 with all rows driven.
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 34; i++) step(1'b0, 4'h0, 4'b0000, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2500; i++)
      step(($urandom_range(0, 3) != 0), 4'($urandom()), rand_rows(),
           ($urandom_range(0, 199) != 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
